// File: rtl/ps_link_checker.sv
// rtl/ps_link_checker.sv - loopback link checker: transmit-byte FIFO compared against deserialized rx bytes
// Hunts for an in-order alignment, then counts matches and errors while locked.
module ps_link_checker #(
  parameter int DEPTH   = 8,
  parameter int LOCK_N  = 4,
  parameter int MAX_ERR = 4
) (
  input  logic        clk_f,
  input  logic        reset,
  input  logic        valid_tx,
  input  logic [7:0]  data_tx,
  input  logic        valid_rx,
  input  logic [7:0]  data_rx,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] match_count,
  output logic [15:0] error_count,
  output logic        overflow,
  output logic [4:0]  level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t          state, state_next;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [7:0]      streak, streak_next;
  logic [7:0]      errs, errs_next;
  logic            empty, full, pop, push, hit;
  logic            count_match, count_err;

  assign empty  = (level == 5'd0);
  assign full   = (level == 5'(DEPTH));
  // Compare always uses the head registered before this edge, so a byte pushed now is not visible.
  assign pop    = valid_rx && !empty;
  assign push   = valid_tx && (!full || pop);
  assign hit    = pop && (mem[rptr] == data_rx);
  assign locked = (state == LOCKED);

  always_comb begin
    state_next  = state;
    streak_next = streak;
    errs_next   = errs;
    count_match = 1'b0;
    count_err   = 1'b0;
    if (valid_rx) begin
      case (state)
        HUNT: begin
          if (hit) begin
            if (streak == 8'(LOCK_N - 1)) begin
              state_next  = LOCKED;
              streak_next = 8'd0;
              errs_next   = 8'd0;
            end else begin
              streak_next = streak + 8'd1;
            end
          end else begin
            streak_next = 8'd0;
          end
        end
        LOCKED: begin
          if (hit) begin
            count_match = 1'b1;
            errs_next   = 8'd0;
          end else begin
            // Underflow (empty FIFO) is counted exactly like a mismatch.
            count_err = 1'b1;
            if (errs == 8'(MAX_ERR - 1)) begin
              state_next  = HUNT;
              streak_next = 8'd0;
              errs_next   = 8'd0;
            end else begin
              errs_next = errs + 8'd1;
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_f) begin
    if (push) mem[wptr] <= data_tx;
  end

  always_ff @(posedge clk_f) begin
    if (reset) begin
      state       <= HUNT;
      streak      <= 8'd0;
      errs        <= 8'd0;
      wptr        <= '0;
      rptr        <= '0;
      level       <= 5'd0;
      overflow    <= 1'b0;
      err_pulse   <= 1'b0;
      match_count <= 16'd0;
      error_count <= 16'd0;
    end else begin
      state     <= state_next;
      streak    <= streak_next;
      errs      <= errs_next;
      err_pulse <= count_err;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
      if (valid_tx && !push) overflow <= 1'b1;
      if (count_match && match_count != 16'hFFFF) match_count <= match_count + 16'd1;
      if (count_err && error_count != 16'hFFFF) error_count <= error_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ps_link_checker.sv
// tb/tb_ps_link_checker.sv - directed scoreboard bench for ps_link_checker
// Each step queues the expected locked/err_pulse for the following cycle; counters are checked at milestones.
module tb_ps_link_checker;

  logic        clk_f = 1'b0;
  logic        reset = 1'b1;
  logic        valid_tx = 1'b0;
  logic [7:0]  data_tx = 8'h00;
  logic        valid_rx = 1'b0;
  logic [7:0]  data_rx = 8'h00;
  logic        locked, err_pulse, overflow;
  logic [15:0] match_count, error_count;
  logic [4:0]  level;

  typedef struct packed {
    logic locked;
    logic err;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  ps_link_checker #(.DEPTH(8), .LOCK_N(4), .MAX_ERR(4)) dut (
    .clk_f(clk_f), .reset(reset),
    .valid_tx(valid_tx), .data_tx(data_tx),
    .valid_rx(valid_rx), .data_rx(data_rx),
    .locked(locked), .err_pulse(err_pulse),
    .match_count(match_count), .error_count(error_count),
    .overflow(overflow), .level(level)
  );

  always #5 clk_f = ~clk_f;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk("locked", 16'(locked), 16'(e.locked));
      chk("err_pulse", 16'(err_pulse), 16'(e.err));
    end
  endtask

  task automatic step(input logic vtx, input logic [7:0] dtx, input logic vrx,
                      input logic [7:0] drx, input logic el, input logic ep);
    valid_tx = vtx;
    data_tx  = dtx;
    valid_rx = vrx;
    data_rx  = drx;
    sb.push_back('{locked: el, err: ep});
    @(posedge clk_f);
    #1;
    valid_tx = 1'b0;
    valid_rx = 1'b0;
    check_out();
  endtask

  // Inputs are held active during reset to show they are ignored.
  task automatic do_reset();
    reset    = 1'b1;
    valid_tx = 1'b1;
    data_tx  = 8'hEE;
    valid_rx = 1'b1;
    data_rx  = 8'hEE;
    sb.push_back('{locked: 1'b0, err: 1'b0});
    @(posedge clk_f);
    #1;
    reset    = 1'b0;
    valid_tx = 1'b0;
    valid_rx = 1'b0;
    check_out();
    chk("rst_level", 16'(level), 16'd0);
    chk("rst_match", match_count, 16'd0);
    chk("rst_error", error_count, 16'd0);
    chk("rst_overflow", 16'(overflow), 16'd0);
  endtask

  logic [7:0] slip_tx [7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
  logic [7:0] slip_rx [7] = '{8'h33, 8'h33, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
  logic [7:0] corr_rx [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hFF, 8'h09, 8'h0A};
  logic [7:0] ovf_rx [8] = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h4A};

  initial begin
    repeat (2) @(posedge clk_f);
    #1;
    do_reset();

    // Clean loopback of 0x01..0x0A
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 8'h00, 1'b0, 1'b0);
    chk("loop_preload_level", 16'(level), 16'd4);
    for (int i = 1; i <= 10; i++) step((i + 4) <= 10, 8'(i + 4), 1'b1, 8'(i), i >= 4, 1'b0);
    chk("loop_match", match_count, 16'd6);
    chk("loop_error", error_count, 16'd0);
    chk("loop_level", 16'(level), 16'd0);

    // Alignment slip: 0x11 and 0x22 discarded in hunt
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, slip_tx[i], 1'b0, 8'h00, 1'b0, 1'b0);
    chk("slip_level", 16'(level), 16'd7);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, slip_rx[i], i >= 5, 1'b0);
    chk("slip_match", match_count, 16'd1);
    chk("slip_error", error_count, 16'd0);
    chk("slip_level_end", 16'(level), 16'd0);

    // Single corruption while locked
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(i < 6, 8'(i + 5), 1'b1, corr_rx[i], i >= 3, i == 7);
      if (i == 7) chk("corr_error_now", error_count, 16'd1);
    end
    chk("corr_match", match_count, 16'd5);
    chk("corr_error", error_count, 16'd1);
    chk("corr_locked", 16'(locked), 16'd1);

    // Loss of lock then re-lock
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b0, 8'h00, 1'b1, 8'(i), i == 4, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h21 + i), 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 8'hFF, i < 3, 1'b1);
    chk("lol_error", error_count, 16'd4);
    chk("lol_match", match_count, 16'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h31 + i), 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 8'(8'h31 + i), i == 3, 1'b0);
    chk("relock_error", error_count, 16'd4);
    chk("relock_match", match_count, 16'd0);

    // Overflow with 9 pushes, then push+pop while full
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 8'(8'h41 + i), 1'b0, 8'h00, 1'b0, 1'b0);
      chk("ovf_level", 16'(level), (i < 8) ? 16'(i + 1) : 16'd8);
      chk("ovf_flag", 16'(overflow), 16'(i == 8));
    end
    step(1'b1, 8'h4A, 1'b1, 8'h41, 1'b0, 1'b0);
    chk("full_pushpop_level", 16'(level), 16'd8);
    chk("full_pushpop_ovf", 16'(overflow), 16'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, ovf_rx[i], i >= 2, 1'b0);
    chk("ovf_match", match_count, 16'd5);
    chk("ovf_error", error_count, 16'd0);
    chk("ovf_sticky", 16'(overflow), 16'd1);

    // Reset mid-stream while locked with three queued bytes
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h51 + i), 1'b0, 8'h00, 1'b1, 1'b0);
    chk("mid_level", 16'(level), 16'd3);
    do_reset();
    step(1'b0, 8'h00, 1'b1, 8'h51, 1'b0, 1'b0);
    chk("post_rst_level", 16'(level), 16'd0);
    step(1'b1, 8'h60, 1'b1, 8'h60, 1'b0, 1'b0);
    chk("empty_pushpop_level", 16'(level), 16'd1);
    step(1'b0, 8'h00, 1'b1, 8'h60, 1'b0, 1'b0);
    chk("post_rst_drain", 16'(level), 16'd0);
    chk("post_rst_match", match_count, 16'd0);
    chk("post_rst_error", error_count, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ps_link_checker.md
PS_LINK_CHECKER -- requirements
Module: ps_link_checker

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of transmit-byte FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter LOCK_N, default 4, meaning the consecutive in-order matches required to declare lock.
REQ-003 The block SHALL have parameter MAX_ERR, default 4, meaning the consecutive mismatches in LOCKED that force re-hunt.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- clk_f  input  1  byte clock, all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_tx  input  1  byte presented to the serializer is valid.
- data_tx  input  8  byte presented to the serializer.
- valid_rx  input  1  deserializer output byte is valid.
- data_rx  input  8  deserializer output byte.
- locked  output  1  high while in LOCKED state.
- err_pulse  output  1  one-cycle pulse per mismatch or underflow counted in LOCKED.
- match_count  output  16  matched bytes counted in LOCKED, saturating.
- error_count  output  16  errors counted in LOCKED, saturating.
- overflow  output  1  sticky flag, a transmit byte was dropped.
- level  output  5  current FIFO occupancy.

Function
REQ-005 When valid_tx=1 and the FIFO is not full, the block SHALL push data_tx at the tail.
REQ-006 When valid_tx=1 and the FIFO is full with no pop in the same cycle, the block SHALL drop the byte and set overflow.
- overflow stays set until reset.
REQ-007 Simultaneous push and pop on a full FIFO SHALL both succeed, and level SHALL remain unchanged.
REQ-008 A pushed byte SHALL NOT be visible for comparison in the cycle it is pushed.
- Compare uses the head as registered before the edge.
- Push and pop on an empty FIFO therefore means the compare sees empty.
REQ-009 Read and write pointers SHALL wrap modulo DEPTH.
- level SHALL equal the pushes minus pops since reset, in the range 0..DEPTH.
REQ-010 The FSM SHALL have two states, HUNT and LOCKED.
- locked is high only in LOCKED.
- locked is registered, so it rises one cycle after the qualifying match.
REQ-011 In HUNT, on valid_rx=1 with the FIFO non-empty, the block SHALL pop the head.
- If head==data_rx, streak is incremented.
- Otherwise streak is set to 0, discarding a byte never received.
REQ-012 In HUNT, on valid_rx=1 with the FIFO empty, the block SHALL set streak to 0 and SHALL NOT pop.
REQ-013 In HUNT, counters and err_pulse SHALL NOT change.
REQ-014 HUNT SHALL go to LOCKED on the cycle the streak reaches LOCK_N.
- On entry, streak is cleared and the consecutive-error count errs is set to 0.
REQ-015 In LOCKED, on valid_rx=1 with the FIFO non-empty, the block SHALL pop the head and compare it with data_rx.
- Match: match_count is incremented and errs is set to 0.
- Mismatch: error_count is incremented, err_pulse=1 next cycle, and errs is incremented.
REQ-016 In LOCKED, on valid_rx=1 with the FIFO empty (underflow), the block SHALL count an error exactly as a mismatch, without popping.
REQ-017 LOCKED SHALL return to HUNT when errs reaches MAX_ERR.
- The transition occurs on the same edge that counts the MAX_ERR-th error.
- Counters are retained.
REQ-018 valid_rx=0 SHALL cause no pop and no state, streak or counter change.
- Idle/COM cycles from the link are ignored.
REQ-019 match_count and error_count SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-020 While reset=1 at a clk_f edge, the block SHALL clear the following.
- The FIFO pointers, with level=0.
- The FSM to HUNT, with streak=0 and errs=0.
- The outputs locked=0, err_pulse=0, match_count=0, error_count=0 and overflow=0.
REQ-021 Reset SHALL take priority over all inputs, and inputs in a reset cycle SHALL be ignored.
REQ-022 Reset asserted mid-stream SHALL discard all queued bytes.
- The first post-reset valid_rx is evaluated in HUNT against an empty FIFO.

Verification
REQ-023 The bench SHALL cover a clean loopback.
- Stimulus: push 0x01..0x0A, then return the same 10 bytes in order on valid_rx.
- Response: locked rises after the 4th match, match_count=6, error_count=0.
REQ-024 The bench SHALL cover alignment slip.
- Stimulus: push 0x11,0x22,0x33..0x77; the rx stream starts at 0x33.
- Response: 0x11 and 0x22 are discarded in HUNT, locked after 0x66, no errors counted.
REQ-025 The bench SHALL cover a single corruption in LOCKED.
- Stimulus: one rx byte is 0xFF instead of the expected 0x08.
- Response: err_pulse for 1 cycle, error_count=1, locked stays 1, the next byte matches.
REQ-026 The bench SHALL cover loss of lock.
- Stimulus: 4 consecutive wrong rx bytes in LOCKED.
- Response: error_count=4, locked falls after the 4th error, and a re-lock follows 4 good bytes.
REQ-027 The bench SHALL cover overflow with DEPTH=8.
- Stimulus: 9 pushes, no valid_rx.
- Response: level=8, overflow=1 sticky, the 9th byte is absent.
- A push and pop while full keeps level=8.
REQ-028 The bench SHALL cover reset mid-stream.
- Stimulus: assert reset for 1 cycle in LOCKED with level=3.
- Response: the next cycle shows level=0, locked=0, both counters 0 and overflow=0.
